// File: rtl/hdlc_rx_channel.sv
// -----------------------------------------------------------------------------
// hdlc_rx_channel
//
// Serial front end of the HDLC receiver. Samples one line bit per clock while
// RxEN is high, detects flags and aborts on the raw stream, removes inserted
// zeros from the delayed stream and assembles destuffed bits into bytes
// (LSB first) for the downstream Rx controller.
//
// Optional feature macro: HDLC_RX_FCS_CHECK_EN
//   defined   : CRC-CCITT (reflected, init 16'hFFFF) over all destuffed frame
//               bits; Rx_FCSErr flags a residue other than 16'hF0B8.
//   undefined : no CRC logic, Rx_FCSErr is tied low.
//
// Parameters
//   FLAG_PATTERN    raw flag octet compared against the delay line
//   ABORT_ONES      consecutive raw ones that abort a frame (7..15)
//
// Ports
//   Clk             in   system clock, rising edge
//   Rst             in   asynchronous reset, active-low
//   Rx              in   serial receive bit
//   RxEN            in   receive enable; low forces IDLE and clears counters
//   Rx_Data         out  last assembled byte, held until the next one
//   Rx_NewByte      out  1-cycle strobe, Rx_Data valid in the same cycle
//   Rx_FlagDetect   out  1-cycle strobe, flag seen
//   Rx_FrameStart   out  1-cycle strobe, frame opened or restarted
//   Rx_FrameEnd     out  1-cycle strobe, closing flag of a non-empty frame
//   Rx_Misaligned   out  with Rx_FrameEnd: destuffed bit count not a multiple of 8
//   Rx_AbortSignal  out  1-cycle strobe, abort while in a frame
//   Rx_FCSErr       out  with Rx_FrameEnd: FCS residue mismatch
// -----------------------------------------------------------------------------
module hdlc_rx_channel #(
    parameter logic [7:0]  FLAG_PATTERN = 8'h7E,
    parameter int unsigned ABORT_ONES   = 7
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       RxEN,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_FlagDetect,
    output logic       Rx_FrameStart,
    output logic       Rx_FrameEnd,
    output logic       Rx_Misaligned,
    output logic       Rx_AbortSignal,
    output logic       Rx_FCSErr
);

    localparam logic [3:0] ABORT_CNT = 4'(ABORT_ONES);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_dly;        // raw delay line, newest bit at [7]
    logic [3:0] r_guard;      // flag bits still draining out of the delay line
    logic [3:0] r_ones_raw;   // run of raw ones, for abort detection
    logic [3:0] r_ones_dst;   // run of delayed data ones, for destuffing
    logic [2:0] r_bitcnt;     // destuffed bits modulo 8
    logic       r_has_data;   // at least one destuffed bit in this frame
    logic [7:0] r_asm;        // byte assembler, LSB first

    logic [7:0] w_dly_next;
    logic       w_dbit;
    logic       w_flag;
    logic [3:0] w_ones_raw_next;
    logic       w_in_data;
    logic       w_stuffed;
    logic       w_accept;
    logic       w_byte_done;
    logic [7:0] w_asm_next;
    logic [2:0] w_bitcnt_next;
    logic       w_has_data_next;
    logic       w_frame_start;
    logic       w_frame_end;
    logic       w_abort;
    logic       w_fcs_bad;

    assign w_dly_next      = {Rx, r_dly[7:1]};
    assign w_dbit          = r_dly[0];
    assign w_flag          = RxEN && (w_dly_next == FLAG_PATTERN);
    assign w_ones_raw_next = Rx ? ((r_ones_raw == 4'hF) ? r_ones_raw : r_ones_raw + 4'd1) : 4'd0;

    // The bit leaving the delay line is data only inside a frame and only once
    // the flag that opened it has fully drained (guard back to zero).
    assign w_in_data       = RxEN && (r_state == ST_FRAME) && (r_guard == 4'd0);
    assign w_stuffed       = w_in_data && !w_dbit && (r_ones_dst == 4'd5);
    assign w_accept        = w_in_data && !w_stuffed;
    assign w_byte_done     = w_accept && (r_bitcnt == 3'd7);
    assign w_asm_next      = {w_dbit, r_asm[7:1]};
    assign w_bitcnt_next   = w_accept ? r_bitcnt + 3'd1 : r_bitcnt;
    assign w_has_data_next = r_has_data || w_accept;

    // -------------------------------------------------------------------------
    // Frame FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_abort       = 1'b0;
        if (!RxEN) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_flag) begin
                        w_state_next  = ST_FRAME;
                        w_frame_start = 1'b1;
                    end
                end
                ST_FRAME: begin
                    if (w_flag) begin
                        // The bit accepted on this same edge still belongs to
                        // the closing frame, hence the _next view.
                        w_frame_start = 1'b1;
                        w_frame_end   = w_has_data_next;
                    end else if (w_ones_raw_next == ABORT_CNT) begin
                        w_state_next = ST_IDLE;
                        w_abort      = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Optional FCS check
    // -------------------------------------------------------------------------
`ifdef HDLC_RX_FCS_CHECK_EN
    logic [15:0] r_crc;
    logic [15:0] w_crc_next;

    always_comb begin
        w_crc_next = r_crc;
        if (w_accept) begin
            w_crc_next = {1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ w_dbit) ? 16'h8408 : 16'h0000);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_crc <= 16'hFFFF;
        end else if (RxEN) begin
            // Re-seeding on a restart happens after the closing check has
            // used w_crc_next, so back-to-back frames share the flag cleanly.
            r_crc <= w_frame_start ? 16'hFFFF : w_crc_next;
        end
    end

    assign w_fcs_bad = (w_crc_next != 16'hF0B8);
`else
    assign w_fcs_bad = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Delay line, destuffing, byte assembly and output strobes
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_dly          <= 8'h00;
            r_guard        <= 4'd0;
            r_ones_raw     <= 4'd0;
            r_ones_dst     <= 4'd0;
            r_bitcnt       <= 3'd0;
            r_has_data     <= 1'b0;
            r_asm          <= 8'h00;
            Rx_Data        <= 8'h00;
            Rx_NewByte     <= 1'b0;
            Rx_FlagDetect  <= 1'b0;
            Rx_FrameStart  <= 1'b0;
            Rx_FrameEnd    <= 1'b0;
            Rx_Misaligned  <= 1'b0;
            Rx_AbortSignal <= 1'b0;
            Rx_FCSErr      <= 1'b0;
        end else if (!RxEN) begin
            // Delay line, assembler and last byte are held; everything that
            // counts toward a frame starts over.
            r_guard        <= 4'd0;
            r_ones_raw     <= 4'd0;
            r_ones_dst     <= 4'd0;
            r_bitcnt       <= 3'd0;
            r_has_data     <= 1'b0;
            Rx_NewByte     <= 1'b0;
            Rx_FlagDetect  <= 1'b0;
            Rx_FrameStart  <= 1'b0;
            Rx_FrameEnd    <= 1'b0;
            Rx_Misaligned  <= 1'b0;
            Rx_AbortSignal <= 1'b0;
            Rx_FCSErr      <= 1'b0;
        end else begin
            r_dly      <= w_dly_next;
            r_ones_raw <= w_ones_raw_next;

            if (w_flag) begin
                r_guard <= 4'd8;
            end else if (r_guard != 4'd0) begin
                r_guard <= r_guard - 4'd1;
            end

            if (w_accept) begin
                r_asm <= w_asm_next;
            end
            if (w_byte_done) begin
                Rx_Data <= w_asm_next;
            end

            if (w_flag || w_abort) begin
                r_ones_dst <= 4'd0;
                r_bitcnt   <= 3'd0;
                r_has_data <= 1'b0;
            end else begin
                if (w_in_data) begin
                    // A dropped stuffed zero also ends the run of ones.
                    r_ones_dst <= w_dbit ? ((r_ones_dst == 4'hF) ? r_ones_dst : r_ones_dst + 4'd1) : 4'd0;
                end
                r_bitcnt   <= w_bitcnt_next;
                r_has_data <= w_has_data_next;
            end

            Rx_NewByte     <= w_byte_done;
            Rx_FlagDetect  <= w_flag;
            Rx_FrameStart  <= w_frame_start;
            Rx_FrameEnd    <= w_frame_end;
            Rx_Misaligned  <= w_frame_end && (w_bitcnt_next != 3'd0);
            Rx_AbortSignal <= w_abort;
            Rx_FCSErr      <= w_frame_end && w_fcs_bad;
        end
    end

endmodule

// File: tb/tb_hdlc_rx_channel.sv
// -----------------------------------------------------------------------------
// tb_hdlc_rx_channel
//
// Directed and randomized bench for hdlc_rx_channel. Frames are built as bit
// queues (payload, FCS, zero insertion, flags) and played onto Rx one bit per
// clock. A reference model working on bit queues predicts every output after
// every edge; directed sections add targeted expectations on top.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hdlc_rx_channel;

    localparam logic [7:0] FLAG  = 8'h7E;
    localparam int         ABORT = 7;

    typedef bit bitq_t[$];

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Rx;
    logic       RxEN;
    logic [7:0] Rx_Data;
    logic       Rx_NewByte;
    logic       Rx_FlagDetect;
    logic       Rx_FrameStart;
    logic       Rx_FrameEnd;
    logic       Rx_Misaligned;
    logic       Rx_AbortSignal;
    logic       Rx_FCSErr;

    hdlc_rx_channel #(
        .FLAG_PATTERN (FLAG),
        .ABORT_ONES   (ABORT)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Rx             (Rx),
        .RxEN           (RxEN),
        .Rx_Data        (Rx_Data),
        .Rx_NewByte     (Rx_NewByte),
        .Rx_FlagDetect  (Rx_FlagDetect),
        .Rx_FrameStart  (Rx_FrameStart),
        .Rx_FrameEnd    (Rx_FrameEnd),
        .Rx_Misaligned  (Rx_Misaligned),
        .Rx_AbortSignal (Rx_AbortSignal),
        .Rx_FCSErr      (Rx_FCSErr)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // observed strobe tallies for the current directed section
    int         n_nb, n_fd, n_fs, n_fe, n_ab;
    int         nb_edge;
    logic [7:0] last_data;
    logic       fe_mis, fe_fcs, fe_nb;

    // frame construction
    bitq_t dq;   // unstuffed payload
    bitq_t tx;   // line bits

    // reference model state
    bitq_t      m_hist;     // last 8 raw bits, oldest first
    bitq_t      m_fbits;    // destuffed bits of the current frame
    bit         m_in_frame;
    int         m_skip;
    int         m_ones;
    int         m_raw;
    logic [7:0] e_data;
    logic       e_nb, e_fd, e_fs, e_fe, e_mis, e_ab, e_fcs;

    function automatic logic [15:0] crc16(input bitq_t q);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) begin
            if (c[0] ^ q[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < 8; i++) m_hist.push_back(1'b0);
        m_fbits.delete();
        m_in_frame = 1'b0;
        m_skip = 0; m_ones = 0; m_raw = 0;
        e_data = 8'h00;
        e_nb = 0; e_fd = 0; e_fs = 0; e_fe = 0; e_mis = 0; e_ab = 0; e_fcs = 0;
    endfunction

    function automatic void model_step(input bit b, input bit en);
        bit d;
        bit flag;
        e_nb = 0; e_fd = 0; e_fs = 0; e_fe = 0; e_mis = 0; e_ab = 0; e_fcs = 0;
        if (!en) begin
            m_in_frame = 1'b0;
            m_skip = 0; m_ones = 0; m_raw = 0;
            m_fbits.delete();
        end else begin
            d = m_hist.pop_front();
            m_hist.push_back(b);
            flag = 1'b1;
            for (int i = 0; i < 8; i++) if (m_hist[i] != FLAG[i]) flag = 1'b0;
            m_raw = b ? ((m_raw < 15) ? m_raw + 1 : 15) : 0;
            if (m_in_frame && m_skip == 0) begin
                if (!d && m_ones == 5) begin
                    m_ones = 0;
                end else begin
                    m_ones = d ? m_ones + 1 : 0;
                    m_fbits.push_back(d);
                    if (m_fbits.size() % 8 == 0) begin
                        e_nb = 1'b1;
                        for (int i = 0; i < 8; i++) e_data[i] = m_fbits[m_fbits.size() - 8 + i];
                    end
                end
            end
            if (m_skip > 0) m_skip--;
            if (flag) begin
                e_fd = 1'b1;
                e_fs = 1'b1;
                if (m_in_frame && m_fbits.size() > 0) begin
                    e_fe  = 1'b1;
                    e_mis = (m_fbits.size() % 8) != 0;
`ifdef HDLC_RX_FCS_CHECK_EN
                    e_fcs = (crc16(m_fbits) != 16'hF0B8);
`endif
                end
                m_in_frame = 1'b1;
                m_fbits.delete();
                m_ones = 0;
                m_skip = 8;
            end else if (m_in_frame && m_raw == ABORT) begin
                e_ab = 1'b1;
                m_in_frame = 1'b0;
                m_fbits.delete();
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"}, 16'(Rx_Data),        16'(e_data));
        chk({tag, ".nb"},   16'(Rx_NewByte),     16'(e_nb));
        chk({tag, ".fd"},   16'(Rx_FlagDetect),  16'(e_fd));
        chk({tag, ".fs"},   16'(Rx_FrameStart),  16'(e_fs));
        chk({tag, ".fe"},   16'(Rx_FrameEnd),    16'(e_fe));
        chk({tag, ".mis"},  16'(Rx_Misaligned),  16'(e_mis));
        chk({tag, ".ab"},   16'(Rx_AbortSignal), 16'(e_ab));
        chk({tag, ".fcs"},  16'(Rx_FCSErr),      16'(e_fcs));
    endtask

    task automatic clr_cnt();
        n_nb = 0; n_fd = 0; n_fs = 0; n_fe = 0; n_ab = 0;
        nb_edge = 0; last_data = 8'h00; fe_mis = 0; fe_fcs = 0; fe_nb = 0;
    endtask

    // one clock: drive, let the edge happen, predict, compare on the falling edge
    task automatic step(input logic b, input logic en);
        Rx = b;
        RxEN = en;
        @(posedge Clk);
        edge_n++;
        model_step(b, en);
        @(negedge Clk);
        check_all("cyc");
        if (Rx_NewByte)     begin n_nb++; last_data = Rx_Data; nb_edge = edge_n; end
        if (Rx_FlagDetect)  n_fd++;
        if (Rx_FrameStart)  n_fs++;
        if (Rx_AbortSignal) n_ab++;
        if (Rx_FrameEnd)    begin n_fe++; fe_mis = Rx_Misaligned; fe_fcs = Rx_FCSErr; fe_nb = Rx_NewByte; end
    endtask

    task automatic dq_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) dq.push_back(v[i]);
    endtask

    task automatic dq_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) dq.push_back(v[i]);
    endtask

    task automatic dq_fcs(input bit corrupt);
        logic [15:0] f;
        f = ~crc16(dq);
        for (int i = 0; i < 16; i++) dq.push_back(f[i]);
        if (corrupt) begin
            int k;
            k = dq.size() - 1 - int'($urandom_range(0, 15));
            dq[k] = ~dq[k];
        end
    endtask

    task automatic tx_flag();
        for (int i = 0; i < 8; i++) tx.push_back(FLAG[i]);
    endtask

    task automatic tx_raw(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) tx.push_back(v[i]);
    endtask

    task automatic tx_stuff();
        int ones;
        ones = 0;
        foreach (dq[i]) begin
            tx.push_back(dq[i]);
            if (dq[i]) begin
                ones++;
                if (ones == 5) begin
                    tx.push_back(1'b0);
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        dq.delete();
    endtask

    task automatic run_tx();
        foreach (tx[i]) step(tx[i], 1'b1);
        tx.delete();
    endtask

    initial begin
        int base;
        int kind;
        int cnt;

        // reset state
        Rst  = 1'b0;
        Rx   = 1'b0;
        RxEN = 1'b0;
        model_reset();
        clr_cnt();
        #2;
        check_all("reset");
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;

        // reset mid-frame: delay line full of a flag, state FRAME
        tx_flag();
        run_tx();
        chk("t1_flag_seen", 16'(Rx_FlagDetect), 16'd1);
        #2;
        Rst = 1'b0;
        model_reset();
        #1;
        check_all("t1_async");
        @(negedge Clk);
        Rst = 1'b1;
        clr_cnt();
        // seven flag bits then a one: no flag, and the 7-ones run must not
        // abort because the frame was dropped by reset
        tx_raw(32'h0000_00FE, 8);
        run_tx();
        chk("t1_no_flag",  16'(n_fd), 16'd0);
        chk("t1_no_abort", 16'(n_ab), 16'd0);

        // flag, A5, flag
        clr_cnt();
        tx_flag();
        dq_byte(8'hA5);
        tx_stuff();
        tx_flag();
        base = edge_n;
        run_tx();
        chk("t2_nb_count", 16'(n_nb), 16'd1);
        chk("t2_data",     16'(last_data), 16'h00A5);
        chk("t2_latency",  16'(nb_edge - base - 15), 16'd9);
        chk("t2_fe",       16'(n_fe), 16'd1);
        chk("t2_fe_w_nb",  16'(fe_nb), 16'd1);
        chk("t2_mis",      16'(fe_mis), 16'd0);

        // flag, FF with stuffed zero, flag
        clr_cnt();
        tx_flag();
        tx_raw(32'h0000_01DF, 9);
        tx_flag();
        run_tx();
        chk("t3_nb_count", 16'(n_nb), 16'd1);
        chk("t3_data",     16'(last_data), 16'h00FF);
        chk("t3_fe",       16'(n_fe), 16'd1);
        chk("t3_mis",      16'(fe_mis), 16'd0);

        // flag, 12 data bits, flag
        clr_cnt();
        tx_flag();
        dq_bits(32'h0000_05A3, 12);
        tx_stuff();
        tx_flag();
        run_tx();
        chk("t4_nb_count", 16'(n_nb), 16'd1);
        chk("t4_data",     16'(last_data), 16'h00A3);
        chk("t4_fe",       16'(n_fe), 16'd1);
        chk("t4_mis",      16'(fe_mis), 16'd1);

        // flag, 12, abort. A zero separates the byte from the ones so its
        // last bit leaves the delay line on the same edge the abort fires.
        clr_cnt();
        tx_flag();
        dq_byte(8'h12);
        tx_stuff();
        tx_raw(32'h0, 1);
        tx_raw(32'h0000_03FF, 10);
        run_tx();
        chk("t5_nb_count", 16'(n_nb), 16'd1);
        chk("t5_data",     16'(last_data), 16'h0012);
        chk("t5_abort",    16'(n_ab), 16'd1);
        chk("t5_no_fe",    16'(n_fe), 16'd0);
        clr_cnt();
        tx_flag();
        tx_flag();
        tx_flag();
        run_tx();
        chk("t5_fs3",      16'(n_fs), 16'd3);
        chk("t5_fe0",      16'(n_fe), 16'd0);

        // FCS: correct, then one FCS bit flipped
        clr_cnt();
        tx_flag();
        dq_byte(8'h01);
        dq_byte(8'h02);
        dq_fcs(1'b0);
        tx_stuff();
        tx_flag();
        run_tx();
        chk("t6_fe",       16'(n_fe), 16'd1);
        chk("t6_fcs_ok",   16'(fe_fcs), 16'd0);
        clr_cnt();
        tx_flag();
        dq_byte(8'h01);
        dq_byte(8'h02);
        dq_fcs(1'b1);
        tx_stuff();
        tx_flag();
        run_tx();
        chk("t6_fe_bad",   16'(n_fe), 16'd1);
`ifdef HDLC_RX_FCS_CHECK_EN
        chk("t6_fcs_bad",  16'(fe_fcs), 16'd1);
`else
        chk("t6_fcs_bad",  16'(fe_fcs), 16'd0);
`endif

        // RxEN drop mid-frame: frame forgotten, reopened without a FrameEnd
        tx_flag();
        tx_raw(32'h0000_000D, 4);
        run_tx();
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b0);
        clr_cnt();
        tx_flag();
        run_tx();
        chk("en_fs",       16'(n_fs), 16'd1);
        chk("en_no_fe",    16'(n_fe), 16'd0);

        // randomized frames: good FCS, bad FCS, odd bit counts, aborts
        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom_range(0, 3));
            tx_raw(32'hFFFF_FFFF, int'($urandom_range(0, 9)));
            tx_flag();
            if (kind == 2) begin
                cnt = int'($urandom_range(1, 40));
                for (int i = 0; i < cnt; i++) dq.push_back(1'($urandom_range(0, 1)));
            end else begin
                cnt = int'($urandom_range(1, 6));
                for (int i = 0; i < cnt; i++) dq_byte(8'($urandom));
                if (kind < 2) dq_fcs(kind == 1);
            end
            tx_stuff();
            if (kind == 3) tx_raw(32'hFFFF_FFFF, int'($urandom_range(ABORT, 12)));
            else           tx_flag();
            run_tx();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
